// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: owns the single memory port shared by the CPU and the DMA
// engine. Drains in-flight CPU transactions before granting the bus to DMA,
// stalls the CPU while DMA owns the port, enforces a CPU hold-off window
// after each release, and keeps grant / cycle-steal statistics.
module dma_bus_arbiter #(
    parameter int WORD_SIZE      = 16,
    parameter int LINE_WIDTH     = 64,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    input  logic                  br,
    output logic                  bg,
    input  logic                  cpu_mem_busy,
    input  logic                  cpu_mem_req,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [WORD_SIZE-1:0]  cpu_addr,
    input  logic [LINE_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    input  logic                  dma_write,
    input  logic [WORD_SIZE-1:0]  dma_addr,
    input  logic [LINE_WIDTH-1:0] dma_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [WORD_SIZE-1:0]  mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    output logic [WORD_SIZE-1:0]  grant_count,
    output logic [WORD_SIZE-1:0]  steal_cycles
);

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        DRAIN   = 2'd1,
        DMA_OWN = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF_CYCLES);

    state_t     state, state_nxt;
    logic       bg_nxt, stall_nxt, grant_inc;
    logic [3:0] hold_cnt, hold_cnt_nxt;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [WORD_SIZE-1:0] sat_inc(input logic [WORD_SIZE-1:0] v);
        if (v == {WORD_SIZE{1'b1}})
            return v;
        return v + WORD_SIZE'(1);
    endfunction

    // Next-state, registered-output and counter decisions for the ownership FSM.
    always_comb begin
        state_nxt    = state;
        bg_nxt       = bg;
        stall_nxt    = cpu_stall;
        hold_cnt_nxt = hold_cnt;
        grant_inc    = 1'b0;
        case (state)
            CPU_OWN: begin
                if (br) begin
                    stall_nxt = 1'b1;
                    if (!cpu_mem_busy && !cpu_mem_req) begin
                        state_nxt = DMA_OWN;
                        bg_nxt    = 1'b1;
                        grant_inc = 1'b1;
                    end else begin
                        // A request launched this cycle still completes; wait it out.
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!br) begin
                    state_nxt = CPU_OWN;
                    stall_nxt = 1'b0;
                end else if (!cpu_mem_busy) begin
                    state_nxt = DMA_OWN;
                    bg_nxt    = 1'b1;
                    grant_inc = 1'b1;
                end
            end
            DMA_OWN: begin
                if (!br) begin
                    bg_nxt    = 1'b0;
                    stall_nxt = 1'b0;
                    if (HOLDOFF_CYCLES == 0) begin
                        state_nxt = CPU_OWN;
                    end else begin
                        state_nxt    = HOLDOFF;
                        hold_cnt_nxt = HOLD_INIT;
                    end
                end
            end
            HOLDOFF: begin
                // br is deliberately ignored until the CPU has had its window.
                if (hold_cnt <= 4'd1) begin
                    state_nxt    = CPU_OWN;
                    hold_cnt_nxt = 4'd0;
                end else begin
                    hold_cnt_nxt = hold_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = CPU_OWN;
                bg_nxt    = 1'b0;
                stall_nxt = 1'b0;
            end
        endcase
    end

    // State, grant/stall outputs and statistics registers.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state        <= CPU_OWN;
            bg           <= 1'b0;
            cpu_stall    <= 1'b0;
            hold_cnt     <= 4'd0;
            grant_count  <= '0;
            steal_cycles <= '0;
        end else begin
            state     <= state_nxt;
            bg        <= bg_nxt;
            cpu_stall <= stall_nxt;
            hold_cnt  <= hold_cnt_nxt;
            if (grant_inc)
                grant_count <= sat_inc(grant_count);
            if (state == DMA_OWN)
                steal_cycles <= steal_cycles + WORD_SIZE'(1);
        end
    end

    // Memory port steering on the registered grant; DMA never reads.
    always_comb begin
        mem_read  = cpu_read;
        mem_write = cpu_write;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (bg) begin
            mem_read  = 1'b0;
            mem_write = dma_write;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Testbench for dma_bus_arbiter: per-scenario tasks with a queue of expected
// grant/stall values pushed as stimulus is applied and popped after each edge.
module tb_dma_bus_arbiter;

    logic        CLK;
    logic        reset_n;
    logic        br;
    logic        bg;
    logic        cpu_mem_busy;
    logic        cpu_mem_req;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic        cpu_stall;
    logic        dma_write;
    logic [15:0] dma_addr;
    logic [63:0] dma_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [15:0] grant_count;
    logic [15:0] steal_cycles;

    typedef struct packed {
        logic bg;
        logic stall;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    dma_bus_arbiter #(
        .WORD_SIZE(16),
        .LINE_WIDTH(64),
        .HOLDOFF_CYCLES(4)
    ) dut (
        .CLK(CLK),
        .reset_n(reset_n),
        .br(br),
        .bg(bg),
        .cpu_mem_busy(cpu_mem_busy),
        .cpu_mem_req(cpu_mem_req),
        .cpu_read(cpu_read),
        .cpu_write(cpu_write),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall),
        .dma_write(dma_write),
        .dma_addr(dma_addr),
        .dma_wdata(dma_wdata),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .grant_count(grant_count),
        .steal_cycles(steal_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset_n = 1'b0; br = 1'b0; cpu_mem_busy = 1'b0; cpu_mem_req = 1'b0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = 16'h0; cpu_wdata = 64'h0;
        dma_write = 1'b0; dma_addr = 16'h0; dma_wdata = 64'h0;
        exp_q.push_back('{bg: 1'b0, stall: 1'b0});
        tick();
        e = exp_q.pop_front();
        checks++; if (bg !== e.bg) begin errors++; $display("FAIL reset_bg got %b exp %b", bg, e.bg); end
        checks++; if (cpu_stall !== e.stall) begin errors++; $display("FAIL reset_stall got %b exp %b", cpu_stall, e.stall); end
        checks++; if (grant_count !== 16'h0) begin errors++; $display("FAIL reset_grant got %h exp 0000", grant_count); end
        checks++; if (steal_cycles !== 16'h0) begin errors++; $display("FAIL reset_steal got %h exp 0000", steal_cycles); end
        reset_n = 1'b1;
    endtask

    task automatic test_idle_grant();
        exp_t e;
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
        dma_write = 1'b1; dma_addr = 16'h01F0; dma_wdata = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (mem_addr !== 16'h1234) begin errors++; $display("FAIL idle_cpu_addr got %h exp 1234", mem_addr); end
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL idle_cpu_read got %b exp 1", mem_read); end
        br = 1'b1;
        exp_q.push_back('{bg: 1'b1, stall: 1'b1});
        tick();
        e = exp_q.pop_front();
        checks++; if (bg !== e.bg) begin errors++; $display("FAIL grant_bg got %b exp %b", bg, e.bg); end
        checks++; if (cpu_stall !== e.stall) begin errors++; $display("FAIL grant_stall got %b exp %b", cpu_stall, e.stall); end
        checks++; if (grant_count !== 16'd1) begin errors++; $display("FAIL grant_count got %0d exp 1", grant_count); end
        checks++; if (mem_addr !== 16'h01F0) begin errors++; $display("FAIL grant_dma_addr got %h exp 01f0", mem_addr); end
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL grant_dma_write got %b exp 1", mem_write); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL grant_no_read got %b exp 0", mem_read); end
        checks++; if (mem_wdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL grant_dma_wdata got %h", mem_wdata); end
        br = 1'b0;
        exp_q.push_back('{bg: 1'b0, stall: 1'b0});
        tick();
        e = exp_q.pop_front();
        checks++; if (bg !== e.bg || cpu_stall !== e.stall) begin errors++; $display("FAIL release bg/stall got %b%b exp %b%b", bg, cpu_stall, e.bg, e.stall); end
        for (int i = 0; i < 4; i++) tick();
        cpu_read = 1'b0; dma_write = 1'b0;
    endtask

    // Row bits: {br, busy, req, exp_bg, exp_stall}
    task automatic test_drain();
        logic [4:0]  tbl[$];
        logic [15:0] g0;
        exp_t        e;
        tbl = '{5'b10101, 5'b11001, 5'b11001, 5'b11001, 5'b11001, 5'b10011,
                5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        g0 = grant_count;
        for (int i = 0; i < tbl.size(); i++) begin
            br = tbl[i][4]; cpu_mem_busy = tbl[i][3]; cpu_mem_req = tbl[i][2];
            exp_q.push_back('{bg: tbl[i][1], stall: tbl[i][0]});
            tick();
            e = exp_q.pop_front();
            checks++; if (bg !== e.bg) begin errors++; $display("FAIL drain_bg row %0d got %b exp %b", i, bg, e.bg); end
            checks++; if (cpu_stall !== e.stall) begin errors++; $display("FAIL drain_stall row %0d got %b exp %b", i, cpu_stall, e.stall); end
        end
        checks++; if (grant_count !== g0 + 16'd1) begin errors++; $display("FAIL drain_grant got %0d exp %0d", grant_count, g0 + 16'd1); end
    endtask

    task automatic test_holdoff();
        logic [4:0]  tbl[$];
        logic [15:0] g0, s0;
        exp_t        e;
        tbl = {};
        tbl.push_back(5'b10011);
        for (int i = 0; i < 11; i++) tbl.push_back(5'b10011);
        tbl.push_back(5'b00000);
        for (int i = 0; i < 4; i++) tbl.push_back(5'b10000);
        tbl.push_back(5'b10011);
        tbl.push_back(5'b00000);
        for (int i = 0; i < 4; i++) tbl.push_back(5'b00000);
        g0 = grant_count; s0 = steal_cycles;
        for (int i = 0; i < tbl.size(); i++) begin
            br = tbl[i][4]; cpu_mem_busy = tbl[i][3]; cpu_mem_req = tbl[i][2];
            exp_q.push_back('{bg: tbl[i][1], stall: tbl[i][0]});
            tick();
            e = exp_q.pop_front();
            checks++; if (bg !== e.bg) begin errors++; $display("FAIL holdoff_bg row %0d got %b exp %b", i, bg, e.bg); end
            checks++; if (cpu_stall !== e.stall) begin errors++; $display("FAIL holdoff_stall row %0d got %b exp %b", i, cpu_stall, e.stall); end
            if (i == 12) begin
                checks++; if (steal_cycles !== s0 + 16'd12) begin errors++; $display("FAIL steal_12 got %0d exp %0d", steal_cycles, s0 + 16'd12); end
            end
        end
        checks++; if (grant_count !== g0 + 16'd2) begin errors++; $display("FAIL holdoff_grants got %0d exp %0d", grant_count, g0 + 16'd2); end
    endtask

    task automatic test_withdraw();
        logic [4:0]  tbl[$];
        logic [15:0] g0;
        exp_t        e;
        tbl = '{5'b11001, 5'b11001, 5'b01000, 5'b00000, 5'b00000};
        g0 = grant_count;
        for (int i = 0; i < tbl.size(); i++) begin
            br = tbl[i][4]; cpu_mem_busy = tbl[i][3]; cpu_mem_req = tbl[i][2];
            exp_q.push_back('{bg: tbl[i][1], stall: tbl[i][0]});
            tick();
            e = exp_q.pop_front();
            checks++; if (bg !== e.bg) begin errors++; $display("FAIL withdraw_bg row %0d got %b exp %b", i, bg, e.bg); end
            checks++; if (cpu_stall !== e.stall) begin errors++; $display("FAIL withdraw_stall row %0d got %b exp %b", i, cpu_stall, e.stall); end
        end
        checks++; if (grant_count !== g0) begin errors++; $display("FAIL withdraw_grant got %0d exp %0d", grant_count, g0); end
    endtask

    task automatic test_reset_mid_grant();
        exp_t e;
        br = 1'b1; cpu_mem_busy = 1'b0; cpu_mem_req = 1'b0;
        exp_q.push_back('{bg: 1'b1, stall: 1'b1});
        tick();
        e = exp_q.pop_front();
        checks++; if (bg !== e.bg) begin errors++; $display("FAIL midreset_pre_bg got %b exp %b", bg, e.bg); end
        reset_n = 1'b0; br = 1'b0; cpu_write = 1'b1; dma_write = 1'b0;
        exp_q.push_back('{bg: 1'b0, stall: 1'b0});
        tick();
        e = exp_q.pop_front();
        checks++; if (bg !== e.bg) begin errors++; $display("FAIL midreset_bg got %b exp %b", bg, e.bg); end
        checks++; if (cpu_stall !== e.stall) begin errors++; $display("FAIL midreset_stall got %b exp %b", cpu_stall, e.stall); end
        checks++; if (grant_count !== 16'h0 || steal_cycles !== 16'h0) begin errors++; $display("FAIL midreset_counters got %h/%h exp 0000/0000", grant_count, steal_cycles); end
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL midreset_cpu_write got %b exp 1", mem_write); end
        reset_n = 1'b1; cpu_write = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        force dut.grant_count = 16'hFFFE;
        #1;
        release dut.grant_count;
        br = 1'b1;
        tick();
        checks++; if (grant_count !== 16'hFFFF || bg !== 1'b1) begin errors++; $display("FAIL sat_reach got %h bg %b exp ffff bg 1", grant_count, bg); end
        force dut.steal_cycles = 16'hFFFE;
        #1;
        release dut.steal_cycles;
        tick();
        checks++; if (steal_cycles !== 16'hFFFF) begin errors++; $display("FAIL steal_pre_wrap got %h exp ffff", steal_cycles); end
        tick();
        checks++; if (steal_cycles !== 16'h0000) begin errors++; $display("FAIL steal_wrap got %h exp 0000", steal_cycles); end
        br = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        br = 1'b1;
        tick();
        checks++; if (grant_count !== 16'hFFFF || bg !== 1'b1) begin errors++; $display("FAIL sat_hold got %h bg %b exp ffff bg 1", grant_count, bg); end
        br = 1'b0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    initial begin
        test_reset();
        test_idle_grant();
        test_drain();
        test_holdoff();
        test_withdraw();
        test_reset_mid_grant();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Owns the single memory port shared by the pipelined CPU (cache line fills/writebacks) and the DMA engine.
- Accepts the DMA bus request (BR) and drains any in-flight CPU memory transaction before issuing the bus grant (BG).
- Stalls the CPU while the DMA holds the bus and steers the memory port to the DMA side.
- Enforces a CPU hold-off window after each release and keeps grant and cycle-steal statistics.

Parameters:
- WORD_SIZE, 16, address width and statistics counter width.
- LINE_WIDTH, 64, memory data width (4 words).
- HOLDOFF_CYCLES, 4, minimum cycles the CPU keeps the bus after a DMA release before BR is honoured again; legal range 0..15.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on rising CLK.
- br  input  1  bus request from DMA.
- bg  output  1  bus grant to DMA; registered.
- cpu_mem_busy  input  1  CPU has an outstanding memory transaction.
- cpu_mem_req  input  1  CPU starts a new memory transaction this cycle.
- cpu_read  input  1  CPU memory read strobe.
- cpu_write  input  1  CPU memory write strobe.
- cpu_addr  input  WORD_SIZE  CPU memory address.
- cpu_wdata  input  LINE_WIDTH  CPU write data.
- cpu_stall  output  1  freezes the CPU memory stage; registered.
- dma_write  input  1  DMA write strobe.
- dma_addr  input  WORD_SIZE  DMA write address.
- dma_wdata  input  LINE_WIDTH  DMA write data.
- mem_read  output  1  muxed read strobe to memory.
- mem_write  output  1  muxed write strobe to memory.
- mem_addr  output  WORD_SIZE  muxed address.
- mem_wdata  output  LINE_WIDTH  muxed write data.
- grant_count  output  WORD_SIZE  number of grants issued; saturates at all-ones.
- steal_cycles  output  WORD_SIZE  cycles with bg=1; wraps modulo 2^WORD_SIZE.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - State goes to CPU_OWN.
  - bg=0, cpu_stall=0, hold-off counter=0, grant_count=0, steal_cycles=0.
  - The same applies mid-grant: bg drops at that edge and DMA strobes are no longer forwarded.
- Memory port mux is combinational on the registered bg:
  - bg=1: mem_* = dma_* and mem_read=0.
  - bg=0: mem_* = cpu_*.
- States:
  - CPU_OWN:
    - If br=1, cpu_mem_busy=0 and cpu_mem_req=0: go to DMA_OWN; bg=1, cpu_stall=1 next cycle (1-cycle BR-to-BG latency); grant_count increments.
    - If br=1 otherwise: go to DRAIN; cpu_stall=1 next cycle. A cpu_mem_req in the same cycle is still accepted and drained.
  - DRAIN:
    - cpu_stall=1, bg=0.
    - If br=0: return to CPU_OWN and deassert cpu_stall (request withdrawn, no grant, no count).
    - Else if cpu_mem_busy=0: go to DMA_OWN with bg=1 next cycle; grant_count increments.
  - DMA_OWN:
    - bg=1, cpu_stall=1; steal_cycles increments every cycle.
    - If br=0: bg=0 and cpu_stall=0 next cycle. Go to HOLDOFF with counter=HOLDOFF_CYCLES, or directly to CPU_OWN if HOLDOFF_CYCLES=0.
  - HOLDOFF:
    - br is ignored; counter decrements each cycle.
    - When counter=1, go to CPU_OWN, so the CPU owns the bus for exactly HOLDOFF_CYCLES cycles.
- bg and cpu_stall never change in the same cycle except on entry to and exit from DMA_OWN.
- grant_count holds at 16'hFFFF once saturated.
- br asserted continuously across a release is re-honoured only after the hold-off window.

Test Plan:
- Idle grant: reset, then br=1 with cpu_mem_busy=0 and cpu_mem_req=0 at cycle 5 -> bg=1 and cpu_stall=1 at cycle 6; grant_count=1; mem_addr follows dma_addr=16'h01F0.
- Drain: cpu_mem_busy=1 for cycles 5..8 with br=1 at cycle 5 -> cpu_stall=1 from cycle 6; bg=0 through cycle 9; bg=1 at cycle 10.
- Release and hold-off (HOLDOFF_CYCLES=4): br held 12 cycles after grant, then br=0 and immediately br=1 again -> bg falls 1 cycle after br falls; stays 0 for 4 cycles; re-grants on the 5th; steal_cycles=12 after the first grant.
- Withdrawn request: br=1 for 2 cycles during drain (cpu_mem_busy=1), then br=0 -> bg never asserts; cpu_stall returns to 0; grant_count unchanged.
- Reset mid-grant: reset_n=0 for one edge while bg=1 -> bg=0, cpu_stall=0, counters=0 on that edge; mem_write follows cpu_write.
- Saturation and wrap: force 65537 grants (or preload via hierarchical access) -> grant_count stays 16'hFFFF; steal_cycles wraps from 16'hFFFF to 0.
